// File: rtl/operand_fwd_mux_pkg.sv
// Shared constants for the operand forwarding mux: source encoding and default geometry.
package operand_fwd_mux_pkg;

  localparam int SRC_RF           = 0;
  localparam int SRC_FWD_BASE     = 1;

  localparam int DEFAULT_WIDTH    = 64;
  localparam int DEFAULT_ADDR_W   = 5;
  localparam int DEFAULT_NUM_FWD  = 3;
  localparam int DEFAULT_ZERO_REG = 31;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  // Saturating increment used by the optional statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    if (value == STAT_MAX) begin
      sat_inc = value;
    end else begin
      sat_inc = value + 32'd1;
    end
  endfunction

endpackage

// File: rtl/operand_fwd_mux_fwd_priority_sel.sv
// Combinational match-and-priority encoder: lowest-index valid forward source whose
// destination equals rs_addr wins; returns a one-hot match and the encoded source.
module fwd_priority_sel
  import operand_fwd_mux_pkg::*;
#(
  parameter int NUM_FWD = DEFAULT_NUM_FWD,
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int SRC_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  output logic [NUM_FWD-1:0]        match_onehot,
  output logic [SRC_W-1:0]          src
);

  logic [NUM_FWD-1:0] raw_match_s;
  logic               found_s;

  // Per-source address compare, qualified by that source's valid flag.
  always_comb begin
    raw_match_s = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      raw_match_s[k] = fwd_valid[k] && (fwd_addr[k*ADDR_W +: ADDR_W] == rs_addr);
    end
  end

  // Priority pick: the first hit scanning from index 0 (youngest stage) wins.
  always_comb begin
    match_onehot = '0;
    src          = SRC_W'(SRC_RF);
    found_s      = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (raw_match_s[k] && !found_s) begin
        found_s         = 1'b1;
        match_onehot[k] = 1'b1;
        src             = SRC_W'(k + SRC_FWD_BASE);
      end else begin
        match_onehot[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/operand_fwd_mux.sv
// Registered operand select with address-matched forwarding and a valid/ready output stage.
// Optional statistics counters are enabled by defining OPERAND_FWD_MUX_STATS_EN.
module operand_fwd_mux
  import operand_fwd_mux_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int NUM_FWD  = DEFAULT_NUM_FWD,
  parameter  int ADDR_W   = DEFAULT_ADDR_W,
  parameter  int ZERO_REG = DEFAULT_ZERO_REG,
  localparam int SRC_W    = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         rs_addr,
  input  logic [WIDTH-1:0]          rf_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*WIDTH-1:0]  fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SRC_W-1:0]          out_src
`ifdef OPERAND_FWD_MUX_STATS_EN
  ,
  output logic [31:0]               fwd_hit_count,
  output logic [31:0]               req_count
`endif
);

  logic [NUM_FWD-1:0] match_onehot_s;
  logic [SRC_W-1:0]   fwd_src_s;
  logic [WIDTH-1:0]   fwd_sel_data_s;
  logic [WIDTH-1:0]   sel_data_s;
  logic [SRC_W-1:0]   sel_src_s;
  logic               is_zero_s;
  logic               accept_s;

  logic               out_valid_r;
  logic [WIDTH-1:0]   out_data_r;
  logic [SRC_W-1:0]   out_src_r;

  fwd_priority_sel #(
    .NUM_FWD (NUM_FWD),
    .ADDR_W  (ADDR_W),
    .SRC_W   (SRC_W)
  ) u_sel (
    .rs_addr      (rs_addr),
    .fwd_valid    (fwd_valid),
    .fwd_addr     (fwd_addr),
    .match_onehot (match_onehot_s),
    .src          (fwd_src_s)
  );

  assign in_ready  = !out_valid_r || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign is_zero_s = (rs_addr == ADDR_W'(ZERO_REG));

  // One-hot AND-OR gather of the winning forward payload.
  always_comb begin
    fwd_sel_data_s = '0;
    for (int k = 0; k < NUM_FWD; k++) begin
      fwd_sel_data_s = fwd_sel_data_s | (fwd_data[k*WIDTH +: WIDTH] & {WIDTH{match_onehot_s[k]}});
    end
  end

  // Zero register overrides any forward hit; otherwise forward beats the register file.
  always_comb begin
    if (is_zero_s) begin
      sel_data_s = '0;
      sel_src_s  = SRC_W'(SRC_RF);
    end else if (|match_onehot_s) begin
      sel_data_s = fwd_sel_data_s;
      sel_src_s  = fwd_src_s;
    end else begin
      sel_data_s = rf_data;
      sel_src_s  = SRC_W'(SRC_RF);
    end
  end

  // Output stage: capture on accept, drop valid on a drain without refill, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_src_r   <= '0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sel_data_s;
      out_src_r   <= sel_src_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;

`ifdef OPERAND_FWD_MUX_STATS_EN
  logic [31:0] fwd_hit_count_r;
  logic [31:0] req_count_r;

  // Saturating counters of accepted requests and of those served by a forward source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_count_r <= 32'd0;
      req_count_r     <= 32'd0;
    end else if (accept_s) begin
      req_count_r <= sat_inc(req_count_r);
      if (sel_src_s != SRC_W'(SRC_RF)) begin
        fwd_hit_count_r <= sat_inc(fwd_hit_count_r);
      end else begin
        fwd_hit_count_r <= fwd_hit_count_r;
      end
    end else begin
      req_count_r <= req_count_r;
    end
  end

  assign fwd_hit_count = fwd_hit_count_r;
  assign req_count     = req_count_r;
`endif

endmodule

// File: tb/tb_operand_fwd_mux.sv
// Directed bench for operand_fwd_mux with a cycle-level reference model and literal pins.
module tb_operand_fwd_mux;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   rs_addr;
  logic [63:0]  rf_data;
  logic [2:0]   fwd_valid;
  logic [14:0]  fwd_addr;
  logic [191:0] fwd_data;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  out_data;
  logic [1:0]   out_src;
`ifdef OPERAND_FWD_MUX_STATS_EN
  logic [31:0]  fwd_hit_count;
  logic [31:0]  req_count;
`endif

  int checks = 0;
  int errors = 0;

  operand_fwd_mux dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs_addr   (rs_addr),
    .rf_data   (rf_data),
    .fwd_valid (fwd_valid),
    .fwd_addr  (fwd_addr),
    .fwd_data  (fwd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef OPERAND_FWD_MUX_STATS_EN
    ,
    .fwd_hit_count (fwd_hit_count),
    .req_count     (req_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference selection: {src, data} straight from the selection rules.
  function automatic logic [65:0] model_pick(input logic [4:0] a, input logic [63:0] rf,
                                             input logic [2:0] fv, input logic [14:0] fa,
                                             input logic [191:0] fd);
    if (a == 5'd31) return {2'd0, 64'd0};
    for (int k = 0; k < 3; k++) begin
      if (fv[k] && fa[k*5 +: 5] == a) return {2'(k + 1), fd[k*64 +: 64]};
    end
    return {2'd0, rf};
  endfunction

  logic        m_valid;
  logic [63:0] m_data;
  logic [1:0]  m_src;
  logic [31:0] m_req;
  logic [31:0] m_hit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 64'd0;
      m_src   <= 2'd0;
      m_req   <= 32'd0;
      m_hit   <= 32'd0;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid <= 1'b1;
      {m_src, m_data} <= model_pick(rs_addr, rf_data, fwd_valid, fwd_addr, fwd_data);
      if (m_req != 32'hFFFF_FFFF) m_req <= m_req + 32'd1;
      if (model_pick(rs_addr, rf_data, fwd_valid, fwd_addr, fwd_data) >> 64 != 66'd0
          && m_hit != 32'hFFFF_FFFF) m_hit <= m_hit + 32'd1;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("FAIL cmp_in_ready t=%0t got=%b want=%b", $time, in_ready, !m_valid || out_ready);
      end
      checks++;
      if (out_valid !== m_valid) begin
        errors++;
        $display("FAIL cmp_out_valid t=%0t got=%b want=%b", $time, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (out_data !== m_data || out_src !== m_src) begin
          errors++;
          $display("FAIL cmp_out t=%0t got=%h/%0d want=%h/%0d", $time, out_data, out_src, m_data, m_src);
        end
      end
`ifdef OPERAND_FWD_MUX_STATS_EN
      checks++;
      if (req_count !== m_req || fwd_hit_count !== m_hit) begin
        errors++;
        $display("FAIL cmp_stats t=%0t got=%0d/%0d want=%0d/%0d", $time, req_count, fwd_hit_count, m_req, m_hit);
      end
`endif
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    fwd_valid = 3'b000;
    fwd_addr  = 15'd0;
    fwd_data  = 192'd0;
  endtask

  task automatic set_fwd(input int k, input logic v, input logic [4:0] a, input logic [63:0] d);
    fwd_valid[k]       = v;
    fwd_addr[k*5 +: 5] = a;
    fwd_data[k*64 +: 64] = d;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; rs_addr = 5'd0; rf_data = 64'd0;
    clear_fwd();
    #12 rst_n = 1'b1;
    step();
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_out_src", {62'd0, out_src}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Register-file path
    in_valid = 1'b1; rs_addr = 5'd3; rf_data = 64'hA5;
    step();
    check("rf_valid", {63'd0, out_valid}, 64'd1);
    check("rf_data", out_data, 64'hA5);
    check("rf_src", {62'd0, out_src}, 64'd0);

    // Two valid matches plus an invalid one at index 0: index 1 wins
    rs_addr = 5'd7; rf_data = 64'h99;
    set_fwd(0, 1'b0, 5'd7, 64'h33);
    set_fwd(1, 1'b1, 5'd7, 64'h11);
    set_fwd(2, 1'b1, 5'd7, 64'h22);
    step();
    check("prio_data", out_data, 64'h11);
    check("prio_src", {62'd0, out_src}, 64'd2);

    // All three match: youngest wins
    fwd_valid = 3'b111;
    step();
    check("all_match_src", {62'd0, out_src}, 64'd1);
    check("all_match_data", out_data, 64'h33);

    // Only oldest matches
    set_fwd(0, 1'b1, 5'd1, 64'h33);
    set_fwd(1, 1'b1, 5'd2, 64'h11);
    step();
    check("oldest_src", {62'd0, out_src}, 64'd3);
    check("oldest_data", out_data, 64'h22);

    // Valid sources, none matching: falls back to register file
    rs_addr = 5'd9; rf_data = 64'h1234;
    step();
    check("nomatch_data", out_data, 64'h1234);
    check("nomatch_src", {62'd0, out_src}, 64'd0);

    // Zero register suppresses a forward hit
    clear_fwd();
    rs_addr = 5'd31; rf_data = 64'h77;
    set_fwd(0, 1'b1, 5'd31, 64'hFF);
    step();
    check("zero_data", out_data, 64'd0);
    check("zero_src", {62'd0, out_src}, 64'd0);

    // Stall hold then drain-and-refill without a bubble
    clear_fwd();
    rs_addr = 5'd4; rf_data = 64'h1;
    step();
    rf_data = 64'h2; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      check("stall_hold_data", out_data, 64'h1);
    end
    out_ready = 1'b1;
    #1 check("unstall_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    check("refill_valid", {63'd0, out_valid}, 64'd1);
    check("refill_data", out_data, 64'h2);
    in_valid = 1'b0;
    step();
    check("drain_valid", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset during a stall
    in_valid = 1'b1; rf_data = 64'h5; out_ready = 1'b0;
    step();
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_data", out_data, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Ten back-to-back accepts, four of them forwarded
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      rs_addr = 5'(8 + i);
      rf_data = 64'(100 + i);
      clear_fwd();
      if (i % 3 == 0) set_fwd(0, 1'b1, 5'(8 + i), 64'(1000 + i));
      step();
    end
    check("burst_last_data", out_data, 64'd1009);
    check("burst_last_src", {62'd0, out_src}, 64'd1);
    in_valid = 1'b0;
    clear_fwd();
    step();
`ifdef OPERAND_FWD_MUX_STATS_EN
    check("stats_req", {32'd0, req_count}, 64'd10);
    check("stats_hit", {32'd0, fwd_hit_count}, 64'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
